// File: rtl/full_sub_struct.sv
// -----------------------------------------------------------------------------
// full_sub_struct
//
// Registered ripple-borrow subtractor built from half-subtractor cells.
// Computes D = (A - Bin - C) mod 2^WIDTH and the borrow out of the MSB stage.
// Each bit is a full-subtractor cell: two half-subtractors plus an OR joining
// their borrows. Results are captured every cycle with one cycle of latency.
//
// Ports:
//   clk   system clock, rising edge active
//   rst   synchronous, active-high reset; clears D and Bout
//   A     minuend, unsigned, WIDTH bits
//   Bin   subtrahend, unsigned, WIDTH bits
//   C     borrow-in into bit 0
//   D     registered difference, WIDTH bits
//   Bout  registered borrow-out of the MSB stage
// -----------------------------------------------------------------------------
module full_sub_struct #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Bin,
  input  logic             C,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  // Output pair of one half-subtractor.
  typedef struct packed {
    logic diff;
    logic borrow;
  } hs_t;

  // Half-subtractor x - y: difference x^y, borrow when x=0 and y=1.
  function automatic hs_t half_sub(input logic x, input logic y);
    hs_t r;
    r.diff   = x ^ y;
    r.borrow = ~x & y;
    return r;
  endfunction

  // borrow[i] is the borrow into cell i; borrow[0] is the external borrow-in.
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;

  assign borrow[0] = C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    hs_t hs1;
    hs_t hs2;

    // First stage subtracts the operand bits, second stage the incoming borrow.
    // At most one of the two stages can borrow, so OR is sufficient.
    assign hs1           = half_sub(A[i], Bin[i]);
    assign hs2           = half_sub(hs1.diff, borrow[i]);
    assign diff[i]       = hs2.diff;
    assign borrow[i+1]   = hs1.borrow | hs2.borrow;
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create simulation/synthesis races.
  always_ff @(posedge clk) begin
    if (rst) begin
      D    <= '0;
      Bout <= 1'b0;
    end else begin
      D    <= diff;
      Bout <= borrow[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_sub_struct.sv
// -----------------------------------------------------------------------------
// tb_full_sub_struct
//
// Self-checking bench for full_sub_struct. Drives a WIDTH=1 and a WIDTH=4
// instance, each with its own reset, and compares the registered outputs with
// an integer-arithmetic reference one cycle after the inputs were applied.
// -----------------------------------------------------------------------------
module tb_full_sub_struct;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [0:0] a1, b1, d1;
  logic       c1, bout1;
  logic [3:0] a4, b4, d4;
  logic       c4, bout4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_sub_struct #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst1), .A (a1), .Bin (b1), .C (c1), .D (d1), .Bout (bout1)
  );

  full_sub_struct #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst (rst4), .A (a4), .Bin (b4), .C (c4), .D (d4), .Bout (bout4)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {borrow, diff} as a (w+1)-bit two's-complement of a - b - c.
  function automatic logic [7:0] ref_sub(input int a, input int b, input int c, input int w);
    int r;
    r = a - b - c;
    return 8'(((r < 0) ? 1 << w : 0) | (r & ((1 << w) - 1)));
  endfunction

  // Advance one edge; inputs set before the call are sampled at that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] v;

    // Reset with non-zero inputs: outputs stay cleared.
    rst1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    rst4 = 1'b1; a4 = 4'd1; b4 = 4'd0; c4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_w1", {7'b0, bout1, d1} & 8'h3, 8'h0);
      check("reset_w4", {3'b0, bout4, d4}, 8'h0);
    end
    rst1 = 1'b0; rst4 = 1'b0;
    step();
    check("release_w1", {6'b0, bout1, d1}, 8'h1);
    check("release_w4", {3'b0, bout4, d4}, 8'h1);

    // Exhaustive WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, c1} = v;
      step();
      check($sformatf("tt_%0d%0d%0d", v[2], v[1], v[0]), {6'b0, bout1, d1},
            ref_sub(v[2], v[1], v[0], 1));
    end

    // Back-to-back alternation 011 / 100.
    for (int i = 0; i < 6; i++) begin
      {a1, b1, c1} = (i % 2 == 0) ? 3'b011 : 3'b100;
      step();
      check("b2b", {6'b0, bout1, d1}, (i % 2 == 0) ? 8'h2 : 8'h1);
    end

    // Reset mid-stream discards the operation sampled with rst=1.
    {a1, b1, c1} = 3'b001;
    step();
    check("mid_pre", {6'b0, bout1, d1}, 8'h3);
    {a1, b1, c1} = 3'b010; rst1 = 1'b1;
    step();
    check("mid_rst", {6'b0, bout1, d1}, 8'h0);
    {a1, b1, c1} = 3'b100; rst1 = 1'b0;
    step();
    check("mid_post", {6'b0, bout1, d1}, 8'h1);

    // WIDTH=4 boundaries.
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b1;
    step();
    check("w4_0_0_1", {3'b0, bout4, d4}, 8'h1F);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b0;
    step();
    check("w4_f_f_0", {3'b0, bout4, d4}, 8'h00);
    a4 = 4'd5; b4 = 4'd3; c4 = 1'b1;
    step();
    check("w4_5_3_1", {3'b0, bout4, d4}, 8'h01);
    a4 = 4'h0; b4 = 4'hF; c4 = 1'b1;
    step();
    check("w4_0_f_1", {3'b0, bout4, d4}, 8'h10);

    // WIDTH=4 random vectors.
    for (int i = 0; i < 1000; i++) begin
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      c4 = 1'($urandom_range(0, 1));
      step();
      check($sformatf("rand_%0d_%0h_%0h_%0d", i, a4, b4, c4), {3'b0, bout4, d4},
            ref_sub(int'(a4), int'(b4), int'(c4), 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
